// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wb_arbiter
//  Description : Two-requester round-robin writeback arbiter with a
//                registered register-file write port and read-hazard flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        p0_valid,
    input  logic [4:0]  p0_wsel,
    input  logic [31:0] p0_wdat,
    output logic        p0_ready,
    input  logic        p1_valid,
    input  logic [4:0]  p1_wsel,
    input  logic [31:0] p1_wdat,
    output logic        p1_ready,
    input  logic        hold,
    input  logic [4:0]  rsel1,
    input  logic [4:0]  rsel2,
    output logic        rf_WEN,
    output logic [4:0]  rf_wsel,
    output logic [31:0] rf_wdat,
    output logic        hazard1,
    output logic        hazard2
);

    logic        r_ptr;
    logic        r_stg_valid;
    logic [4:0]  r_stg_wsel;
    logic [31:0] r_stg_wdat;
    logic        w_gnt0;
    logic        w_gnt1;

    // The pointer only breaks ties; a lone requester always wins.
    assign w_gnt0 = ~hold & p0_valid & (~p1_valid | ~r_ptr);
    assign w_gnt1 = ~hold & p1_valid & (~p0_valid |  r_ptr);

    assign p0_ready = w_gnt0;
    assign p1_ready = w_gnt1;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_ptr <= 1'b0;
        end else if (w_gnt0) begin
            r_ptr <= 1'b1;
        end else if (w_gnt1) begin
            r_ptr <= 1'b0;
        end
    end

    // Select and data hold their last value when nothing is granted.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_stg_valid <= 1'b0;
            r_stg_wsel  <= 5'd0;
            r_stg_wdat  <= 32'd0;
        end else begin
            r_stg_valid <= w_gnt0 | w_gnt1;
            if (w_gnt0) begin
                r_stg_wsel <= p0_wsel;
                r_stg_wdat <= p0_wdat;
            end else if (w_gnt1) begin
                r_stg_wsel <= p1_wsel;
                r_stg_wdat <= p1_wdat;
            end
        end
    end

    assign rf_WEN  = r_stg_valid & (r_stg_wsel != 5'd0);
    assign rf_wsel = r_stg_wsel;
    assign rf_wdat = r_stg_wdat;

    assign hazard1 = rf_WEN & (r_stg_wsel == rsel1);
    assign hazard2 = rf_WEN & (r_stg_wsel == rsel2);

endmodule
`default_nettype wire
